dac_trig_sched: RTL and testbench
=================================

DAC_TRIG_SCHED -- requirements
Module: dac_trig_sched

Interface
REQ-001 Parameter NREQ, default 4: number of trigger requesters.
REQ-002 Parameter CNT_W, default 16: width of trig_count.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  global arm; 0 blocks new grants.
REQ-007 req  in  NREQ  level requests; held until matching ack.
REQ-008 src_mask  in  NREQ  1 = requester ignored.
REQ-009 holdoff  in  10  inter-pulse gap in cycles; sampled on entering ISSUE.
REQ-010 ack  out  NREQ  one-hot, one-cycle completion strobe.
REQ-011 trig_out  out  1  one-cycle pulse to the DAC trigger generator trig input.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 last_src  out  clog2(NREQ)  index of the most recent grant.
REQ-014 trig_count  out  CNT_W  total trig_out pulses issued.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, HOLD and DONE, encoded in the package enum.
REQ-016 IDLE: if enable=1 and (req & ~src_mask)!=0, register the grant index and go to ISSUE; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin, searching upward from last_src+1 modulo NREQ.
REQ-018 ISSUE: trig_out=1 for exactly this cycle; load hold_cnt=max(holdoff,1); go to HOLD.
REQ-019 HOLD: decrement hold_cnt each cycle; at 1, go to DONE, or to ISSUE if burst pulses remain.
REQ-020 DONE: ack[grant]=1 for this cycle only; update last_src; go to IDLE.
REQ-021 Latency SHALL be:
- req sampled high in IDLE at edge N -> trig_out high in cycle N+1.
- ack high in cycle N+2+H, where H = max(holdoff,1).
REQ-022 Requesters SHALL drop req at the edge after ack; DONE performs no arbitration.
REQ-023 trig_count SHALL increment on each trig_out pulse and wrap from 2^CNT_W-1 to 0.
REQ-024 Deasserting enable or changing src_mask mid-sequence SHALL NOT abort it; the sequence completes including ack.
REQ-025 A req dropped before ack SHALL NOT abort the sequence; ack is still issued.
REQ-026 holdoff=0 SHALL behave as holdoff=1.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst=1 SHALL force the following, regardless of state:
- FSM to IDLE.
- ack=0, trig_out=0, busy=0, last_src=NREQ-1, trig_count=0.
- Internal counters cleared.
REQ-029 Reset mid-sequence SHALL produce no ack for the aborted grant; the first grant after reset goes to requester 0 if it is requesting.

Configuration
REQ-030 Macro DAC_TRIG_SCHED_BURST_EN SHALL control burst support.
REQ-031 With the macro defined:
- Port burst_len (in, 4 bits) is present and sampled with the grant.
- Each grant issues burst_len+1 trig_out pulses, each separated by a HOLD of H cycles.
- A single ack follows the final HOLD.
REQ-032 Without the macro, the burst_len port is absent and each grant issues exactly one pulse.

Structure
REQ-033 Package dac_trig_pkg SHALL hold:
- The state enum.
- NREQ and CNT_W defaults.
- HOLD_W=10.
- The 201-cycle generator window constant.
REQ-034 Round-robin selection SHALL live in sub-module dac_trig_rr_arb, combinational and parameterised by NREQ; the FSM stays in dac_trig_sched.

Verification
REQ-035 Single request: req=0001, holdoff=5 -> trig_out in cycle N+1, ack=0001 in cycle N+7, trig_count=1.
REQ-036 Contention: req=1111 held and re-raised after each ack -> grants in order 0,1,2,3,0.
REQ-037 Masking and enable:
- src_mask=0100 with req=0100 -> no trig_out.
- enable=0 with any req -> no trig_out; enable dropped mid-HOLD -> sequence still completes with ack.
REQ-038 Reset and holdoff edge cases:
- rst asserted in HOLD -> next cycle IDLE, ack=0, trig_count=0.
- holdoff=0 -> gap of 1 cycle.
REQ-039 Burst, with the macro defined: burst_len=2, holdoff=3 -> three trig_out pulses spaced 4 cycles apart, one ack, trig_count+=3.
REQ-040 Counter wrap: preload by issuing 2^CNT_W pulses -> trig_count returns to 0.

Source files
------------

// File: rtl/dac_trig_pkg.sv
// Shared types and constants for the DAC trigger scheduler.
package dac_trig_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int HOLD_W     = 10;
    localparam int GEN_WINDOW = 201;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A holdoff of zero still leaves one HOLD cycle between pulses.
    function automatic logic [HOLD_W-1:0] eff_hold(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_W'(1) : h;
    endfunction

endpackage

// File: rtl/dac_trig_rr_arb.sv
// Combinational round-robin picker: searches upward from last_i+1, wrapping at NREQ.
module dac_trig_rr_arb #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest eligible requester wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last_i) + off) % NREQ);
            if (req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/dac_trig_sched.sv
// Round-robin DAC trigger scheduler: IDLE -> ISSUE -> HOLD -> DONE per grant.
// Define DAC_TRIG_SCHED_BURST_EN to add the burst_len port (burst_len+1 pulses per grant).
module dac_trig_sched
    import dac_trig_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   src_mask,
    input  logic [HOLD_W-1:0] holdoff,
`ifdef DAC_TRIG_SCHED_BURST_EN
    input  logic [3:0]        burst_len,
`endif
    output logic [NREQ-1:0]   ack,
    output logic              trig_out,
    output logic              busy,
    output logic [IDX_W-1:0]  last_src,
    output logic [CNT_W-1:0]  trig_count
);

    state_e            state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_src_q;
    logic [CNT_W-1:0]  trig_count_q;
    logic [NREQ-1:0]   ack_q;
    logic              trig_out_q;
    logic              busy_q;
`ifdef DAC_TRIG_SCHED_BURST_EN
    logic [3:0]        burst_q;
`endif

    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic [HOLD_W-1:0] hold_ld_d;
    logic [CNT_W-1:0]  trig_count_d;
    logic [NREQ-1:0]   ack_d;
    logic              more_pulses_d;

    dac_trig_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i       (req & ~src_mask),
        .last_i      (last_src_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign hold_ld_d    = eff_hold(holdoff);
    assign trig_count_d = trig_count_q + CNT_W'(1);

`ifdef DAC_TRIG_SCHED_BURST_EN
    assign more_pulses_d = (burst_q != 4'd0);
`else
    assign more_pulses_d = 1'b0;
`endif

    always_comb begin
        ack_d          = '0;
        ack_d[grant_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            grant_q      <= '0;
            last_src_q   <= IDX_W'(NREQ - 1);
            trig_count_q <= '0;
            ack_q        <= '0;
            trig_out_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef DAC_TRIG_SCHED_BURST_EN
            burst_q      <= '0;
`endif
        end else begin
            // NOTE: strobes default low here; a later non-blocking write in the case overrides it.
            ack_q      <= '0;
            trig_out_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && gnt_valid) begin
                        grant_q      <= gnt_idx;
                        hold_cnt_q   <= hold_ld_d;
                        trig_out_q   <= 1'b1;
                        trig_count_q <= trig_count_d;
                        busy_q       <= 1'b1;
`ifdef DAC_TRIG_SCHED_BURST_EN
                        burst_q      <= burst_len;
`endif
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(1)) begin
                        if (more_pulses_d) begin
                            hold_cnt_q   <= hold_ld_d;
                            trig_out_q   <= 1'b1;
                            trig_count_q <= trig_count_d;
`ifdef DAC_TRIG_SCHED_BURST_EN
                            burst_q      <= burst_q - 4'd1;
`endif
                            state_q      <= ST_ISSUE;
                        end else begin
                            ack_q   <= ack_d;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    last_src_q <= grant_q;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign trig_out   = trig_out_q;
    assign busy       = busy_q;
    assign last_src   = last_src_q;
    assign trig_count = trig_count_q;

endmodule

// File: tb/tb_dac_trig_sched.sv
// Scoreboard bench for dac_trig_sched: expected pulses/acks queued at drive time, popped by a monitor.
module tb_dac_trig_sched;
    import dac_trig_pkg::*;

    localparam int NREQ  = 4;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   src_mask = '0;
    logic [HOLD_W-1:0] holdoff = '0;
`ifdef DAC_TRIG_SCHED_BURST_EN
    logic [3:0]        burst_len = '0;
    int                tb_burst = 0;
`endif
    logic [NREQ-1:0]   ack;
    logic              trig_out;
    logic              busy;
    logic [1:0]        last_src;
    logic [CNT_W-1:0]  trig_count;

    dac_trig_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req        (req),
        .src_mask   (src_mask),
        .holdoff    (holdoff),
`ifdef DAC_TRIG_SCHED_BURST_EN
        .burst_len  (burst_len),
`endif
        .ack        (ack),
        .trig_out   (trig_out),
        .busy       (busy),
        .last_src   (last_src),
        .trig_count (trig_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t trig_q[$];
    exp_t ack_q[$];

    int m_last  = NREQ - 1;
    int m_count = 0;
    int m_ready = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] elig, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            if (elig[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every observed pulse/ack must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (trig_out) begin
            if (trig_q.size() == 0) begin
                check("trig_unexpected", 32'(trig_out), 32'd0);
            end else begin
                e = trig_q.pop_front();
                check("trig_cycle", cyc, e.cyc);
                check("trig_count", 32'(trig_count), e.val);
            end
        end
        if (ack != '0) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                e = ack_q.pop_front();
                check("ack_cycle", cyc, e.cyc);
                check("ack_vec", 32'(ack), e.val);
            end
        end
    end

    // mid: 0 none, 1 drop enable, 2 drop req, 3 mask everything (applied in HOLD)
    task automatic txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] m, input logic en,
                       input int hold, input int mid);
        int   n;
        int   idx;
        int   h;
        int   nb;
        exp_t e;
        wait_until(m_ready - 1);
        check("last_src", 32'(last_src), m_last);
        check("busy_idle", 32'(busy), 32'd0);
        req      = r;
        src_mask = m;
        enable   = en;
        holdoff  = HOLD_W'(hold);
`ifdef DAC_TRIG_SCHED_BURST_EN
        burst_len = 4'(tb_burst);
        nb        = tb_burst + 1;
`else
        nb        = 1;
`endif
        n   = cyc + 1;
        idx = rr_pick(r & ~m, m_last);
        if (en && idx >= 0) begin
            h = (hold == 0) ? 1 : hold;
            for (int p = 0; p < nb; p++) begin
                m_count = (m_count + 1) % (1 << CNT_W);
                e.cyc   = n + p * (h + 1);
                e.val   = m_count;
                trig_q.push_back(e);
            end
            e.cyc = n + nb * (h + 1);
            e.val = 32'(1) << idx;
            ack_q.push_back(e);
            m_last  = idx;
            m_ready = n + nb * (h + 1) + 2;
            if (mid != 0) begin
                wait_until(n + 1);
                case (mid)
                    1:       enable   = 1'b0;
                    2:       req      = '0;
                    default: src_mask = '1;
                endcase
            end
        end else begin
            m_ready = n + 1;
        end
    endtask

    initial begin
        #(GEN_WINDOW * 1000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   n;
        exp_t e_drop;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_trig", 32'(trig_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last_src", 32'(last_src), NREQ - 1);
        check("rst_count", 32'(trig_count), 32'd0);
        rst     = 1'b0;
        m_ready = cyc + 1;

        // Contention: all four held, expect 0,1,2,3,0
        for (int i = 0; i < 5; i++) txn(4'b1111, 4'b0000, 1'b1, 2, 0);
        // Single request, holdoff 5
        txn(4'b0001, 4'b0000, 1'b1, 5, 0);
        // Masked requester and disabled arm: nothing issued
        txn(4'b0100, 4'b0100, 1'b1, 3, 0);
        txn(4'b0100, 4'b0100, 1'b1, 3, 0);
        txn(4'b1111, 4'b0000, 1'b0, 3, 0);
        txn(4'b1111, 4'b0000, 1'b0, 3, 0);
        // Mid-sequence disturbances never abort
        txn(4'b0010, 4'b0000, 1'b1, 4, 1);
        txn(4'b1000, 4'b0000, 1'b1, 3, 2);
        txn(4'b0100, 4'b0000, 1'b1, 2, 3);
        // holdoff 0 behaves as 1
        txn(4'b0010, 4'b0000, 1'b1, 0, 0);
        txn(4'b0011, 4'b0000, 1'b1, 1, 0);
`ifdef DAC_TRIG_SCHED_BURST_EN
        tb_burst = 2;
        txn(4'b0001, 4'b0000, 1'b1, 3, 0);
        tb_burst = 0;
        txn(4'b0100, 4'b0000, 1'b1, 1, 0);
`endif

        // Reset in HOLD: no ack, counters cleared
        txn(4'b0100, 4'b0000, 1'b1, 8, 0);
        n = cyc + 1;
        wait_until(n + 3);
        rst = 1'b1;
        wait_until(n + 4);
        check("mrst_ack", 32'(ack), 32'd0);
        check("mrst_trig", 32'(trig_out), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_count", 32'(trig_count), 32'd0);
        check("mrst_last_src", 32'(last_src), NREQ - 1);
        rst     = 1'b0;
        e_drop  = ack_q.pop_back();
        m_count = 0;
        m_last  = NREQ - 1;
        m_ready = cyc + 1;

        // First grant after reset goes to 0; 2^CNT_W pulses wrap the counter
        for (int i = 0; i < (1 << CNT_W); i++) txn(4'b1111, 4'b0000, 1'b1, 1, 0);
        wait_until(m_ready - 1);
        req    = '0;
        enable = 1'b0;
        check("wrap_count", 32'(trig_count), 32'd0);
        check("wrap_last_src", 32'(last_src), m_last);

        wait_until(m_ready + 6);
        check("trig_q_drained", trig_q.size(), 32'd0);
        check("ack_q_drained", ack_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
